latch_bank_write_ctrl: RTL and testbench
========================================

# latch_bank_write_ctrl

Write sequencer and arbiter for a bank of `dlatch`-based registers, i.e. transparent active-high D latches with a shared active-low clear. Two requesters, writeback (port 0) and load (port 1), share the bank. Latches are level-sensitive, so the block turns each granted write into a glitch-free setup / enable / hold sequence and issues bank-wide clears. All latch-facing outputs are registered, so no combinational path reaches a latch enable.

## Interface
- `WIDTH`, default 8, latch data width.
- `NREGS`, default 4, number of latch registers in the bank.
- `AW`, default 2, address width; must satisfy 2^AW >= NREGS.

- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0`, `req1` input 1 each: write requests; level, held until the matching ack.
- `addr0`, `addr1` input AW each: target register.
- `data0`, `data1` input WIDTH each: write data.
- `ack0`, `ack1` output 1 each: one-cycle write-complete pulses.
- `clr_req` input 1: request a bank-wide clear; level.
- `clr_ack` output 1: one-cycle pulse, high during the clear cycle.
- `lat_d` output WIDTH: data bus to all latch `d` inputs.
- `lat_en` output NREGS: one-hot latch enables.
- `lat_nclr` output 1: shared active-low latch clear.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Reset values: `lat_en`=0, `lat_d`=0, `lat_nclr`=1, `ack0`/`ack1`/`clr_ack`=0, `busy`=0, state IDLE, round-robin pointer favours port 0.
- States: IDLE, SETUP, PULSE, HOLD, CLEAR.
- IDLE, arbitration priority:
  - `clr_req` wins first and goes to CLEAR.
  - Otherwise, if both `req0` and `req1` are high, the port not granted last wins.
  - Otherwise the single requesting port wins.
  - Accept captures addr/data internally, updates the pointer, and goes to SETUP.
- SETUP: `lat_d` = captured data, `lat_en`=0. Next state PULSE.
- PULSE: `lat_en[addr]`=1, `lat_d` held. Next state HOLD.
- HOLD: `lat_en`=0, `lat_d` held, `ack` of the granted port = 1. Next state IDLE.
- CLEAR: `lat_nclr`=0, `clr_ack`=1, `lat_en`=0. Next state IDLE.
- `lat_d` keeps its last value in IDLE and CLEAR. It changes only on entry to SETUP.
- Address >= NREGS: the full sequence still runs, `lat_en` stays all-zero, and the ack is still issued.
- Requester rules:
  - Addr and data are sampled only at accept, so later changes are ignored.
  - A requester must drop `req` the cycle after its ack, or keep it high to request another write.
  - Dropping `req` before ack is illegal. Once accepted, the controller completes the sequence regardless.
- A `clr_req` that arrives mid-write waits until IDLE.
- `clr_req` held high repeats a CLEAR every other cycle (CLEAR, IDLE, CLEAR...). Requester ports starve while it is held.
- At most one bit of `lat_en` is high in any cycle.
- `lat_en` and `lat_nclr`=0 are never asserted together.

## Timing
- Request accepted at edge k (state IDLE, `req` high):
  - SETUP during cycle k+1.
  - PULSE during cycle k+2.
  - HOLD with ack during cycle k+3.
  - IDLE during cycle k+4.
- The next accept can occur at edge k+4. Throughput is 1 write per 4 cycles.
- Clear: accept at edge k, CLEAR during cycle k+1, IDLE during cycle k+2.
- Data is stable on `lat_d` for one full cycle before and one full cycle after the enable pulse.
- Async `rst` mid-sequence forces all outputs to their reset values immediately, including dropping `lat_en` mid-pulse. No ack is issued for the aborted write.

## Configuration
- `LATCH_WR_LONG_PULSE_EN`:
  - Defined: PULSE lasts 2 cycles (`lat_en` high during k+2 and k+3), HOLD is in cycle k+4, ack during k+4, IDLE during k+5. Throughput is 1 write per 5 cycles. For slow discrete-gate latch builds.
  - Undefined: 1-cycle PULSE as described above.
  - CLEAR duration is unaffected either way.

## Test plan
- Reset then a single write. `req0`=1, `addr0`=2, `data0`=0xA5 accepted at edge k.
  - `lat_d`=0xA5 from k+1.
  - `lat_en`=4'b0100 only in k+2.
  - `ack0` pulses in k+3; `busy` falls at k+4.
- Contention. `req0` and `req1` held continuously from reset.
  - Grants alternate 0,1,0,1.
  - Acks arrive 4 cycles apart.
  - Each `lat_en` pulse matches its port's address.
- Clear priority. `clr_req` and `req1` rise together in IDLE.
  - `lat_nclr`=0 and `clr_ack`=1 next cycle.
  - The port 1 write starts the cycle after.
- Clear during a write. `clr_req` rises in PULSE.
  - The write completes with its ack.
  - CLEAR follows, with no overlap of `lat_en` and `lat_nclr`.
- Abort. Assert `rst` during PULSE.
  - `lat_en`=0 immediately; `ack0` never pulses; state is IDLE.
  - The next write after reset behaves as in the first scenario.
- Out of range and config. NREGS=3, addr=3: ack issued, `lat_en` stays 0. Rerun the first scenario with `LATCH_WR_LONG_PULSE_EN` defined: `lat_en` high in k+2 and k+3, ack in k+4.

Source files
------------

// File: rtl/latch_bank_write_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_write_ctrl
//
// Write sequencer and arbiter for a bank of transparent active-high D latches
// that share an active-low clear. Two requesters (port 0 = writeback,
// port 1 = load) share the bank. Each granted write becomes a
// setup / enable / hold sequence, so data is stable around the enable pulse.
// Bank-wide clears are issued on request. Every latch-facing output comes
// straight from a flop, so no combinational path reaches a latch enable.
//
// Optional build macro:
//   LATCH_WR_LONG_PULSE_EN - stretch the enable pulse to two cycles
//                            (for slow discrete-gate latch builds).
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   req0/req1      write requests (level, held until matching ack)
//   addr0/addr1    target register index (AW bits)
//   data0/data1    write data (WIDTH bits)
//   ack0/ack1      one-cycle write-complete pulses
//   clr_req        bank clear request (level)
//   clr_ack        one-cycle pulse during the clear cycle
//   lat_d          data bus to all latch d inputs
//   lat_en         one-hot latch enables (NREGS bits)
//   lat_nclr       shared active-low latch clear
//   busy           high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module latch_bank_write_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic [WIDTH-1:0] lat_d,
    output logic [NREGS-1:0] lat_en,
    output logic             lat_nclr,
    output logic             busy
);

`ifdef LATCH_WR_LONG_PULSE_EN
    localparam logic LONG_PULSE = 1'b1;
`else
    localparam logic LONG_PULSE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Sequencer context captured at accept.
    logic             last_q, last_d;      // 1 = port 1 was granted most recently
    logic             port_q, port_d;      // port owning the write in flight
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pulse_cnt_q, pulse_cnt_d;
    logic             grant1;

    // Registered outputs; their next values are derived from state_d so each
    // output lines up with the state it belongs to.
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [NREGS-1:0] lat_en_q, lat_en_d;
    logic             lat_nclr_q, lat_nclr_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             clr_ack_q, clr_ack_d;
    logic             busy_q, busy_d;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;          // so port 0 wins the first contention
            port_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            pulse_cnt_q <= 1'b0;
            lat_d_q     <= '0;
            lat_en_q    <= '0;
            lat_nclr_q  <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            clr_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pulse_cnt_q <= pulse_cnt_d;
            lat_d_q     <= lat_d_d;
            lat_en_q    <= lat_en_d;
            lat_nclr_q  <= lat_nclr_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            clr_ack_q   <= clr_ack_d;
            busy_q      <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pulse_cnt_d = 1'b0;
        // Port 1 wins when it is alone, or when both request and port 0 went last.
        grant1      = req1 && (!req0 || !last_q);

        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                end else if (req0 || req1) begin
                    port_d  = grant1;
                    last_d  = grant1;
                    addr_d  = grant1 ? addr1 : addr0;
                    data_d  = grant1 ? data1 : data0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: begin
                // Long-pulse builds spend one extra cycle here.
                if (LONG_PULSE && !pulse_cnt_q) begin
                    pulse_cnt_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_IDLE;
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (next values of the output registers)
    // -------------------------------------------------------------------------
    always_comb begin
        // lat_d only moves on entry to SETUP, which is only reachable from IDLE.
        lat_d_d    = (state_d == S_SETUP) ? data_d : lat_d_q;
        lat_nclr_d = (state_d != S_CLEAR);
        clr_ack_d  = (state_d == S_CLEAR);
        ack0_d     = (state_d == S_HOLD) && !port_d;
        ack1_d     = (state_d == S_HOLD) &&  port_d;
        busy_d     = (state_d != S_IDLE);
    end

    // One decoder bit per latch; an address >= NREGS matches no bit, so the
    // sequence runs with all enables low.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_en
            assign lat_en_d[gi] = (state_d == S_PULSE) && (addr_d == AW'(gi));
        end
    endgenerate

    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
    assign lat_nclr = lat_nclr_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign clr_ack  = clr_ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_write_ctrl
//
// Randomized bench for latch_bank_write_ctrl with NREGS=3 so address 3 is out
// of range. A transaction-level reference model predicts, at each clock edge,
// whether a clear or a write is accepted. It then pushes the expected outcome
// (edges of enable and ack, target address, data) into a scoreboard queue.
// A monitor on the falling edge compares the DUT's latch-facing outputs with
// the front scoreboard entry. It pops the entry when its ack is due.
// -----------------------------------------------------------------------------
module tb_latch_bank_write_ctrl;
    localparam int WIDTH = 8;
    localparam int NREGS = 3;
    localparam int AW    = 2;
`ifdef LATCH_WR_LONG_PULSE_EN
    localparam int PL = 2;
`else
    localparam int PL = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]    addr0 = '0, addr1 = '0;
    logic [WIDTH-1:0] data0 = '0, data1 = '0;
    logic             ack0, ack1, clr_ack, lat_nclr, busy;
    logic [WIDTH-1:0] lat_d;
    logic [NREGS-1:0] lat_en;

    latch_bank_write_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .lat_d(lat_d), .lat_en(lat_en), .lat_nclr(lat_nclr), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = write port 0, 1 = write port 1, 2 = clear
    typedef struct {
        int               kind;
        int               addr;
        logic [WIDTH-1:0] data;
        int               acc;     // accept edge
        int               ack_e;   // edge after which the ack/clr_ack is visible
    } exp_t;

    exp_t             sb_q[$];
    exp_t             m_t;
    int               ecnt      = 0;
    int               next_ok   = 0;
    int               last_port = 1;
    logic [WIDTH-1:0] exp_lat_d = '0;
    int               checks    = 0;
    int               errors    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            sb_q.delete();
            next_ok   = ecnt + 1;
            last_port = 1;
            exp_lat_d = '0;
        end else if (ecnt >= next_ok) begin
            if (clr_req) begin
                m_t.kind  = 2;
                m_t.addr  = 0;
                m_t.data  = '0;
                m_t.acc   = ecnt;
                m_t.ack_e = ecnt;
                sb_q.push_back(m_t);
                next_ok = ecnt + 2;
            end else if (req0 || req1) begin
                if (req0 && req1) m_t.kind = 1 - last_port;
                else              m_t.kind = req1 ? 1 : 0;
                last_port = m_t.kind;
                m_t.addr  = (m_t.kind == 1) ? int'(addr1) : int'(addr0);
                m_t.data  = (m_t.kind == 1) ? data1 : data0;
                m_t.acc   = ecnt;
                m_t.ack_e = ecnt + 1 + PL;
                exp_lat_d = m_t.data;
                sb_q.push_back(m_t);
                next_ok = m_t.ack_e + 2;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [NREGS-1:0] en_x;
        logic             nclr_x, busy_x, a0_x, a1_x, ca_x;
        exp_t             f;
        if (!rst) begin
            en_x = '0; nclr_x = 1'b1; busy_x = 1'b0;
            a0_x = 1'b0; a1_x = 1'b0; ca_x = 1'b0;
            if (sb_q.size() > 0) begin
                f = sb_q[0];
                busy_x = 1'b1;
                if (f.kind == 2) begin
                    nclr_x = 1'b0;
                    ca_x   = 1'b1;
                end else begin
                    if (ecnt >= f.acc + 1 && ecnt <= f.ack_e - 1 && f.addr < NREGS)
                        en_x = NREGS'(1) << f.addr;
                    if (ecnt == f.ack_e) begin
                        a0_x = (f.kind == 0);
                        a1_x = (f.kind == 1);
                    end
                end
            end
            chk("lat_en",   32'(lat_en),   32'(en_x));
            chk("lat_nclr", 32'(lat_nclr), 32'(nclr_x));
            chk("busy",     32'(busy),     32'(busy_x));
            chk("ack0",     32'(ack0),     32'(a0_x));
            chk("ack1",     32'(ack1),     32'(a1_x));
            chk("clr_ack",  32'(clr_ack),  32'(ca_x));
            chk("lat_d",    32'(lat_d),    32'(exp_lat_d));
            chk("en_onehot", 32'($countones(lat_en) <= 1), 32'd1);
            chk("en_nclr_excl", 32'((|lat_en) && !lat_nclr), 32'd0);
            if (sb_q.size() > 0 && sb_q[0].ack_e == ecnt) begin
                $display("txn edge=%0d kind=%0d addr=%0d data=%02h", ecnt, f.kind, f.addr, f.data);
                void'(sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cycle(input int raise_pct, input int keep_pct,
                               input int clr_pct, input int clr_keep_pct);
        @(negedge clk);
        if (req0) begin
            if (ack0) begin
                if ($urandom_range(99) < keep_pct) begin
                    addr0 = AW'($urandom_range(3)); data0 = WIDTH'($urandom);
                end else req0 = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                addr0 = AW'($urandom_range(3)); data0 = WIDTH'($urandom);
            end
        end else if ($urandom_range(99) < raise_pct) begin
            req0 = 1'b1; addr0 = AW'($urandom_range(3)); data0 = WIDTH'($urandom);
        end
        if (req1) begin
            if (ack1) begin
                if ($urandom_range(99) < keep_pct) begin
                    addr1 = AW'($urandom_range(3)); data1 = WIDTH'($urandom);
                end else req1 = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                addr1 = AW'($urandom_range(3)); data1 = WIDTH'($urandom);
            end
        end else if ($urandom_range(99) < raise_pct) begin
            req1 = 1'b1; addr1 = AW'($urandom_range(3)); data1 = WIDTH'($urandom);
        end
        if (clr_req) begin
            if (clr_ack && $urandom_range(99) >= clr_keep_pct) clr_req = 1'b0;
        end else if ($urandom_range(99) < clr_pct) clr_req = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((req0 || req1 || clr_req || busy) && n < 60) begin
            drive_cycle(0, 0, 0, 0);
            n++;
        end
        chk(name, 32'(req0 || req1 || clr_req || busy), 32'd0);
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (lat_en == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(lat_en != '0), 32'd1);
    endtask

    task automatic single_write();
        int n = 0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
        do begin
            @(negedge clk);
            n++;
        end while (!ack0 && n < 20);
        chk("single_ack0_seen", 32'(ack0), 32'd1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lat_en",   32'(lat_en),   32'd0);
        chk("rst_lat_d",    32'(lat_d),    32'd0);
        chk("rst_lat_nclr", 32'(lat_nclr), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_acks",     32'({ack0, ack1, clr_ack}), 32'd0);
        #2 rst = 1'b0;

        // Reset then a single write to register 2.
        single_write();

        // Contention: both ports request continuously.
        repeat (60) drive_cycle(100, 100, 0, 0);
        drain("contention_drain");

        // Clear and port 1 rise together while idle.
        @(negedge clk);
        clr_req = 1'b1; req1 = 1'b1; addr1 = 2'd1; data1 = 8'h3C;
        drain("clr_prio_drain");

        // Clear arriving while the enable pulse is high.
        @(negedge clk);
        req0 = 1'b1; addr0 = 2'd0; data0 = 8'h5A;
        wait_en("midwrite_en_seen");
        clr_req = 1'b1;
        drain("midwrite_clr_drain");

        // Abort: reset during the enable pulse.
        @(negedge clk);
        req0 = 1'b1; addr0 = 2'd1; data0 = 8'hC3;
        wait_en("abort_en_seen");
        #2 rst = 1'b1;
        #1;
        chk("abort_lat_en",   32'(lat_en),   32'd0);
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_ack0",     32'(ack0),     32'd0);
        chk("abort_lat_nclr", 32'(lat_nclr), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        single_write();

        // Randomized traffic including clears and out-of-range addresses.
        repeat (1500) drive_cycle(30, 50, 6, 20);
        drain("random_drain");
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
